// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one imem request in flight, handles EX redirects, and holds or flushes IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode,
    output logic [2:0]  if_func3,
    output logic        if_func7
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign pc_inc       = pc_q + 32'd4;

    // HOLD parks the already-accepted word in the buffer, so no request is issued.
    assign imem_req  = (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    // An unfinished request must still complete before the new address may be issued.
                    if (!imem_ready) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ready && !stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata;
                    pc_d       = pc_inc;
                end else if (imem_ready) begin
                    buf_pc_d    = pc_q;
                    buf_instr_d = imem_rdata;
                    pc_d        = pc_inc;
                    state_d     = HOLD;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = buf_pc_q;
                    if_instr_d = buf_instr_q;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (redirect_valid || !stall) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc_q + 32'd4;
    assign if_instr  = if_instr_q;
    assign if_opcode = if_instr_q[6:0];
    assign if_func3  = if_instr_q[14:12];
    assign if_func7  = if_instr_q[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; memory word at address A is A + 0x100.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_ready;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_pc4, if_instr;
    logic [6:0]  if_opcode;
    logic [2:0]  if_func3;
    logic        if_func7;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 32'h100;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr),
        .if_opcode(if_opcode), .if_func3(if_func3), .if_func7(if_func7)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
        step();
        step();
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        n_cmp++; if (if_instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", if_instr, NOP); end
        n_cmp++; if (if_opcode !== 7'h13 || if_func3 !== 3'd0 || if_func7 !== 1'b0)
            begin n_bad++; $display("FAIL reset_fields: got %h/%h/%b want 13/0/0", if_opcode, if_func3, if_func7); end
        n_cmp++; if (if_pc4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc4: got %h want 4", if_pc4); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_bad++; $display("FAIL reset_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'(k * 4) || if_instr !== 32'(k * 4 + 'h100))
                begin n_bad++; $display("FAIL stream_%0d: got v=%b pc=%h ins=%h want 1/%h/%h",
                    k, if_valid, if_pc, if_instr, 32'(k * 4), 32'(k * 4 + 'h100)); end
            n_cmp++; if (imem_addr !== 32'(k * 4 + 4) || if_pc4 !== 32'(k * 4 + 4))
                begin n_bad++; $display("FAIL stream_addr_%0d: got addr=%h pc4=%h want %h", k, imem_addr, if_pc4, 32'(k * 4 + 4)); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0C || if_instr !== 32'h10C)
                begin n_bad++; $display("FAIL stall_hold_%0d: got req=%b v=%b pc=%h ins=%h want 0/1/0c/10c",
                    k, imem_req, if_valid, if_pc, if_instr); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'h110)
            begin n_bad++; $display("FAIL stall_release: got v=%b pc=%h ins=%h want 1/10/110", if_valid, if_pc, if_instr); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14)
            begin n_bad++; $display("FAIL stall_resume_addr: got req=%b addr=%h want 1/14", imem_req, imem_addr); end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_instr !== 32'h114)
            begin n_bad++; $display("FAIL stall_next: got v=%b pc=%h ins=%h want 1/14/114", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_ready();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL redir_addr: got %h want 200", imem_addr); end
        n_cmp++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h14)
            begin n_bad++; $display("FAIL redir_flush: got v=%b ins=%h pc=%h want 0/%h/14", if_valid, if_instr, if_pc, NOP); end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h300)
            begin n_bad++; $display("FAIL redir_target: got v=%b pc=%h ins=%h want 1/200/300", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_slow_redirect();
        imem_ready = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h204)
            begin n_bad++; $display("FAIL slow_bubble: got v=%b addr=%h want 0/204", if_valid, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h204 || if_valid !== 1'b0)
                begin n_bad++; $display("FAIL slow_drain_%0d: got req=%b addr=%h v=%b want 1/204/0", k, imem_req, imem_addr, if_valid); end
            if (k < 2) step();
        end
        imem_ready = 1'b1;
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h80)
            begin n_bad++; $display("FAIL slow_dropped: got v=%b addr=%h want 0/80", if_valid, imem_addr); end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== 32'h180)
            begin n_bad++; $display("FAIL slow_target: got v=%b pc=%h ins=%h want 1/80/180", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        step();
        n_cmp++; if (imem_req !== 1'b0 || if_pc !== 32'h80 || if_valid !== 1'b1)
            begin n_bad++; $display("FAIL ovr_hold: got req=%b pc=%h v=%b want 0/80/1", imem_req, if_pc, if_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013)
            begin n_bad++; $display("FAIL ovr_flush: got v=%b ins=%h want 0/00000013", if_valid, if_instr); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
            begin n_bad++; $display("FAIL ovr_addr: got req=%b addr=%h want 1/40", imem_req, imem_addr); end
        stall = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h140)
            begin n_bad++; $display("FAIL ovr_target: got v=%b pc=%h ins=%h want 1/40/140", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_fields();
        redirect_valid = 1'b1; redirect_pc = 32'h4000_3000;
        step();
        redirect_valid = 1'b0;
        step();
        n_cmp++; if (if_instr !== 32'h4000_3100 || if_opcode !== 7'h00 || if_func3 !== 3'd3 || if_func7 !== 1'b1)
            begin n_bad++; $display("FAIL fields: got ins=%h op=%h f3=%h f7=%b want 40003100/00/3/1",
                if_instr, if_opcode, if_func3, if_func7); end
    endtask

    task automatic test_wrap_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        step();
        n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h0000_00FC || if_pc4 !== 32'h0 || imem_addr !== 32'h0)
            begin n_bad++; $display("FAIL wrap_edge: got pc=%h ins=%h pc4=%h addr=%h want fffffffc/fc/0/0",
                if_pc, if_instr, if_pc4, imem_addr); end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h100 || imem_addr !== 32'h4)
            begin n_bad++; $display("FAIL wrap_next: got v=%b pc=%h ins=%h addr=%h want 1/0/100/4",
                if_valid, if_pc, if_instr, imem_addr); end
        step();
        imem_ready = 1'b0;
        rst = 1'b1;
        step();
        n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_bad++; $display("FAIL midrst: got v=%b pc=%h ins=%h req=%b addr=%h want 0/0/%h/1/0",
                if_valid, if_pc, if_instr, imem_req, imem_addr, NOP); end
        imem_ready = 1'b1;
        rst = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h100)
            begin n_bad++; $display("FAIL postrst: got v=%b pc=%h ins=%h want 1/0/100", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_ready();
        test_slow_redirect();
        test_redirect_over_stall();
        test_fields();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. Owns the program counter and issues one instruction-memory request at a time over a req/ready handshake. Applies branch/jump redirects from EX and holds or flushes the IF/ID register. Presents a valid-tagged instruction plus its pre-sliced opcode/func3/func7 fields directly to the decode control unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- NOP_INSTR, 32'h0000_0013, instruction word driven on if_instr whenever the IF/ID slot is empty

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- stall  in  1  hold IF/ID contents (hazard unit / cache_busy)
- redirect_valid  in  1  taken branch or jump resolved in EX
- redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 0
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  word-aligned request address
- imem_ready  in  1  response valid this cycle for the address on imem_addr; may be combinational from imem_req
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- if_valid  out  1  IF/ID slot holds a real instruction
- if_pc  out  32  PC of the instruction in IF/ID
- if_pc4  out  32  if_pc+4, modulo 2^32
- if_instr  out  32  instruction in IF/ID (NOP_INSTR when if_valid=0)
- if_opcode  out  7  if_instr[6:0]
- if_func3  out  3  if_instr[14:12]
- if_func7  out  1  if_instr[30]

## Operation
- Registers: pc (next fetch address), drain_addr, buffer (instr + pc), state ∈ {FETCH, HOLD, DRAIN}, and the IF/ID register (if_valid, if_pc, if_instr).
- Handshake: while imem_req=1, imem_addr stays stable until a cycle with imem_ready=1. At most one request is outstanding. imem_ready is ignored when imem_req=0.
- FETCH: imem_req=1, imem_addr=pc.
  - redirect_valid=1: pc←redirect_pc; IF/ID←empty. If imem_ready=1, drop the response and stay in FETCH. Otherwise drain_addr←pc and go to DRAIN.
  - else imem_ready=1 and stall=0: IF/ID←{1, pc, imem_rdata}; pc←pc+4.
  - else imem_ready=1 and stall=1: buffer←{pc, imem_rdata}; pc←pc+4; go to HOLD. IF/ID unchanged.
  - else imem_ready=0: if stall=0, IF/ID←empty (bubble); if stall=1, IF/ID unchanged.
- HOLD: imem_req=0.
  - redirect_valid=1: discard buffer; pc←redirect_pc; IF/ID←empty; go to FETCH.
  - else stall=0: IF/ID←buffer (valid); go to FETCH.
  - else remain in HOLD.
- DRAIN: imem_req=1, imem_addr=drain_addr. A response is dropped on imem_ready=1, then go to FETCH. redirect_valid=1 in DRAIN only updates pc←redirect_pc. IF/ID←empty whenever stall=0 or redirect_valid=1.
- "IF/ID←empty" means if_valid←0, if_instr←NOP_INSTR, if_pc unchanged.
- Priority: rst > redirect_valid > stall > normal advance. A redirect flushes IF/ID even when stall=1.
- Arithmetic: all PC increments are 32-bit and wrap from 32'hFFFF_FFFC to 0. pc[1:0] is always 0.

## Timing
- Reset (synchronous): pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0, if_instr=NOP_INSTR, drain_addr=0, buffer cleared. In the reset cycle imem_req=1 and imem_addr=RESET_PC take effect after the first clk edge with rst=1. Reset asserted mid-request abandons the request; a late imem_ready is ignored because the address has restarted.
- Latency: an address is accepted with imem_ready at edge N, and the instruction appears in IF/ID after edge N. The first instruction after reset is visible in the cycle after the first ready.
- Throughput: one instruction per cycle with imem_ready held high and stall=0.
- Redirect: asserted in cycle N. The first target-path instruction can enter IF/ID no earlier than edge N+1 (FETCH with ready), or after the drain completes.
- Outputs if_opcode/func3/func7/pc4 are combinational slices of the IF/ID registers; no extra latency.

## Test plan
- Reset + streaming: RESET_PC=0, imem_ready=1 always, mem[i]=i*4+0x100. Required: if_valid rises one cycle after reset release; if_pc increments 0,4,8,… with if_instr matching mem every cycle.
- Stall with buffer: stall=1 for 3 cycles while the response for pc=0x10 arrives. Required: HOLD entered, imem_req=0; IF/ID holds 0x0C; after stall drops, IF/ID gets 0x10 then 0x14 with no loss or duplication.
- Redirect with ready: redirect_valid=1, redirect_pc=0x203 while imem_ready=1. Required: next imem_addr=0x200; the dropped response never appears; if_valid=0 for one cycle.
- Redirect during slow fetch: imem_ready=0 for 4 cycles, redirect to 0x80 in cycle 2. Required: imem_addr stays at the old pc until ready; that response is discarded; then the fetch at 0x80 is delivered.
- Redirect overrides stall: stall=1 and redirect_valid=1 together in HOLD. Required: buffer discarded, if_valid=0, if_instr=0x00000013, next imem_addr=redirect target.
- Wrap + mid-run reset: pc=0xFFFFFFFC with ready; then rst=1 mid-stream. Required: the next pc is 0x0; after reset all outputs return to their reset values.
